// File: rtl/rotabit_seq_if.sv
// Command/status bundle between a sequencing controller and rotabit_seq.
// The run input exists only when ROTABIT_FREE_RUN_EN is defined.
interface rotabit_seq_if #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter int STEP_W = 4
);
    logic              load;
    logic [WIDTH-1:0]  din;
    logic              start;
    logic [CNT_W-1:0]  steps;
    logic [STEP_W-1:0] amt;
    logic              dir;
    logic              mode;
    logic [WIDTH-1:0]  x;
    logic              busy;
    logic              done;
`ifdef ROTABIT_FREE_RUN_EN
    logic              run;
`endif

    modport master (
`ifdef ROTABIT_FREE_RUN_EN
        output run,
`endif
        output load, din, start, steps, amt, dir, mode,
        input  x, busy, done
    );

    modport slave (
`ifdef ROTABIT_FREE_RUN_EN
        input  run,
`endif
        input  load, din, start, steps, amt, dir, mode,
        output x, busy, done
    );
endinterface

// File: rtl/rotabit_seq.sv
// Programmable rotate/logical-shift sequencer: load a pattern, then run N barrel steps.
// Define ROTABIT_FREE_RUN_EN to add the legacy free-running rotate-left-by-1 in IDLE.
module rotabit_seq #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter int STEP_W = 4
) (
    input logic          clk,
    input logic          rst,
    rotabit_seq_if.slave bus
);
    localparam int unsigned W_U = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  x_q, x_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              busy_q, busy_nx;
    logic              done_q, done_nx;
    logic              latch;
    logic [STEP_W-1:0] amt_q;
    logic              dir_q;
    logic              mode_q;

    // Rotation via a doubled word: the wrapped bits fall into the kept half.
    function automatic logic [WIDTH-1:0] rot_op(input logic [WIDTH-1:0] v,
                                                input int unsigned s,
                                                input logic d);
        logic [2*WIDTH-1:0] dbl;
        int unsigned        eff;
        eff = s % W_U;
        dbl = {v, v};
        if (d) begin
            dbl = dbl >> eff;
            return dbl[WIDTH-1:0];
        end
        dbl = dbl << eff;
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] v,
                                                  input int unsigned s,
                                                  input logic d);
        if (s >= W_U) return '0;
        return d ? (v >> s) : (v << s);
    endfunction

    function automatic logic [WIDTH-1:0] step_op(input logic [WIDTH-1:0] v,
                                                 input int unsigned s,
                                                 input logic d,
                                                 input logic m);
        return m ? shift_op(v, s, d) : rot_op(v, s, d);
    endfunction

    always_comb begin
        state_nx = state;
        x_nx     = x_q;
        cnt_nx   = cnt;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (bus.load) begin
                    x_nx = bus.din;
                end else if (bus.start) begin
                    latch = 1'b1;
                    if (bus.steps != '0) begin
                        cnt_nx   = bus.steps;
                        busy_nx  = 1'b1;
                        state_nx = RUN;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end
`ifdef ROTABIT_FREE_RUN_EN
                end else if (bus.run) begin
                    x_nx = rot_op(x_q, 32'd1, 1'b0);
`endif
                end
            end
            RUN: begin
                x_nx   = step_op(x_q, 32'(amt_q), dir_q, mode_q);
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            x_q    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            x_q    <= x_nx;
            cnt    <= cnt_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    // Run parameters are frozen at start so mid-run input changes are harmless.
    always_ff @(posedge clk) begin
        if (latch) begin
            amt_q  <= bus.amt;
            dir_q  <= bus.dir;
            mode_q <= bus.mode;
        end
    end

    assign bus.x    = x_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
